fetch_stage: RTL and testbench

Instruction-fetch stage with integrated IF/ID pipeline register: owns the PC, fetches 24-bit instructions from instruction memory over a request/valid handshake, and presents them to the decode stage (control unit and register file) with PC and valid. Supports hazard-unit stall, pipeline flush, and branch/jump redirect from execute. A redirect cancels any in-flight fetch.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_stage_ifid.sv | 56 +++++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states,
// the NOP encoding and the opcode map used by the control unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [23:0] NOP_INSTR = 24'h000000;

  localparam logic [3:0] OP_R  = 4'b0001;
  localparam logic [3:0] OP_I  = 4'b0010;
  localparam logic [3:0] OP_BR = 4'b1000;
  localparam logic [3:0] OP_J  = 4'b0100;
  localparam logic [3:0] OP_LD = 4'b1100;
  localparam logic [3:0] OP_ST = 4'b0011;

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register: flush beats stall beats load;
// an edge with nothing to load inserts a NOP bubble.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_stall,
  input  logic               i_load,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [PC_W-1:0]    i_pc_plus1,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_plus1
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_pc_plus1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_instr    <= INSTR_W'(NOP_INSTR);
      r_pc       <= '0;
      r_pc_plus1 <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= INSTR_W'(NOP_INSTR);
    end else if (!i_stall) begin
      if (i_load) begin
        r_valid    <= 1'b1;
        r_instr    <= i_instr;
        r_pc       <= i_pc;
        r_pc_plus1 <= i_pc_plus1;
      end else begin
        // bubble keeps the last pc so decode still sees a sane address
        r_valid <= 1'b0;
        r_instr <= INSTR_W'(NOP_INSTR);
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus1 = r_pc_plus1;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake,
// redirect kill of in-flight fetch, and the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 24,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_plus1
);

  fetch_state_e       r_state;
  logic [PC_W-1:0]    r_pc;
  logic               r_kill;
  logic [INSTR_W-1:0] r_buf;

  logic [PC_W-1:0]    w_pc_plus1;
  logic               w_hit;
  logic               w_load;
  logic [INSTR_W-1:0] w_instr;

  assign w_pc_plus1 = r_pc + PC_W'(1);
  assign w_hit      = (r_state == ST_WAIT) && imem_rvalid && !r_kill;
  assign w_load     = !redirect_valid && !stall
                    && (w_hit || (r_state == ST_HOLD));
  assign w_instr    = (r_state == ST_HOLD) ? r_buf : imem_rdata;

  assign imem_req  = rst_n && (r_state == ST_ISSUE);
  assign imem_addr = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ISSUE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_buf   <= '0;
    end else begin
      if (w_load)
        r_pc <= w_pc_plus1;
      if (redirect_valid)
        r_pc <= redirect_pc;
      unique case (r_state)
        ST_ISSUE: begin
          // the request at the old pc still goes out; its data is killed
          r_state <= ST_WAIT;
          r_kill  <= redirect_valid;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            r_kill <= 1'b0;
            if (r_kill || redirect_valid || !stall) begin
              r_state <= ST_ISSUE;
            end else begin
              r_buf   <= imem_rdata;
              r_state <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            r_kill <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_valid || !stall)
            r_state <= ST_ISSUE;
        end
        default: r_state <= ST_ISSUE;
      endcase
    end
  end

  ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_stall    (stall),
    .i_load     (w_load),
    .i_instr    (w_instr),
    .i_pc       (r_pc),
    .i_pc_plus1 (w_pc_plus1),
    .o_valid    (ifid_valid),
    .o_instr    (ifid_instr),
    .o_pc       (ifid_pc),
    .o_pc_plus1 (ifid_pc_plus1)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-configurable imem model,
// a transaction-level fetch model and per-cycle output comparison.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [23:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [23:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_plus1;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus1  (ifid_pc_plus1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  typedef struct { logic [15:0] pc; bit dead; } fl_t;
  typedef struct { logic [15:0] addr; int due; } mr_t;
  fl_t infl[$];
  mr_t mq[$];
  int  e = 0;
  int  lat = 1;
  bit  stray = 1'b0;

  logic [15:0] m_pc;
  bit          m_hasbuf;
  logic [23:0] m_buf;
  logic [15:0] m_bufpc;
  bit          m_valid;
  logic [23:0] m_instr;
  logic [15:0] m_ipc;
  logic [15:0] m_ipc1;

  function automatic logic [23:0] memdata(input logic [15:0] a);
    case (a)
      16'h0000: return 24'h100123;
      16'h0001: return 24'h200456;
      16'h0002: return 24'h300789;
      default:  return {8'h5A, a};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic bit m_req();
    return infl.size() == 0 && !m_hasbuf;
  endfunction

  task automatic m_reset();
    infl.delete();
    m_pc = 16'h0000;
    m_hasbuf = 1'b0;
    m_buf = '0;
    m_bufpc = '0;
    m_valid = 1'b0;
    m_instr = NOP_INSTR;
    m_ipc = '0;
    m_ipc1 = '0;
  endtask

  // Fetch behaviour in terms of requests in flight and a parked word.
  task automatic m_step(input bit st, input bit fl, input bit rd,
                        input logic [15:0] rpc, input bit rv,
                        input logic [23:0] rdat);
    bit          del;
    logic [23:0] di;
    logic [15:0] dp;
    fl_t         f;
    del = 1'b0;
    di = '0;
    dp = '0;
    if (m_req()) begin
      f.pc = m_pc;
      f.dead = rd;
      infl.push_back(f);
    end else if (infl.size() > 0) begin
      if (rv) begin
        f = infl.pop_front();
        if (!f.dead && !rd) begin
          if (!st) begin
            del = 1'b1; di = rdat; dp = f.pc;
          end else begin
            m_hasbuf = 1'b1; m_buf = rdat; m_bufpc = f.pc;
          end
        end
      end else if (rd) begin
        f = infl.pop_front();
        f.dead = 1'b1;
        infl.push_front(f);
      end
    end else if (rd) begin
      m_hasbuf = 1'b0;
    end else if (!st) begin
      del = 1'b1; di = m_buf; dp = m_bufpc; m_hasbuf = 1'b0;
    end
    if (del) m_pc = dp + 16'd1;
    if (rd) m_pc = rpc;
    if (fl) begin
      m_valid = 1'b0; m_instr = NOP_INSTR;
    end else if (!st) begin
      if (del) begin
        m_valid = 1'b1; m_instr = di; m_ipc = dp; m_ipc1 = dp + 16'd1;
      end else begin
        m_valid = 1'b0; m_instr = NOP_INSTR;
      end
    end
  endtask

  task automatic tick(input bit st, input bit fl, input bit rd,
                      input logic [15:0] rpc);
    bit          rv;
    logic [23:0] rdat;
    mr_t         r;
    rv = 1'b0;
    rdat = '0;
    if (mq.size() > 0 && mq[0].due == e) begin
      rv = 1'b1;
      rdat = memdata(mq[0].addr);
      mq.delete(0);
    end
    if (stray) begin
      rv = 1'b1; rdat = 24'hDEAD01; stray = 1'b0;
    end
    if (imem_req) begin
      r.addr = imem_addr; r.due = e + lat;
      mq.push_back(r);
    end
    stall = st; flush = fl; redirect_valid = rd; redirect_pc = rpc;
    imem_rvalid = rv; imem_rdata = rdat;
    m_step(st, fl, rd, rpc, rv, rdat);
    @(posedge clk);
    e++;
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input bit v, input logic [15:0] pc,
                     input logic [23:0] ins, input logic [15:0] pc1);
    chk({nm, ".valid"}, 32'(ifid_valid), 32'(v));
    chk({nm, ".pc"}, 32'(ifid_pc), 32'(pc));
    chk({nm, ".instr"}, 32'(ifid_instr), 32'(ins));
    chk({nm, ".pc1"}, 32'(ifid_pc_plus1), 32'(pc1));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", 32'(imem_req), 32'(m_req()));
      if (m_req()) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("ifid_instr", 32'(ifid_instr), 32'(m_instr));
      chk("ifid_pc", 32'(ifid_pc), 32'(m_ipc));
      chk("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(m_ipc1));
    end
  end

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst.req", 32'(imem_req), 32'h0);
    lit("rst", 1'b0, 16'h0, 24'h0, 16'h0);
    rst_n = 1'b1;
    #1;
    chk("first.req", 32'(imem_req), 32'h1);
    chk("first.addr", 32'(imem_addr), 32'h0);
    chk_en = 1'b1;

    tick(0, 0, 0, 16'h0);
    tick(0, 0, 0, 16'h0);
    lit("f0", 1'b1, 16'h0000, 24'h100123, 16'h0001);
    tick(0, 0, 0, 16'h0);
    tick(0, 0, 0, 16'h0);
    lit("f1", 1'b1, 16'h0001, 24'h200456, 16'h0002);
    chk("f2.addr", 32'(imem_addr), 32'h2);

    tick(0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 16'h0);
      chk("stall.req", 32'(imem_req), 32'h0);
    end
    tick(0, 0, 0, 16'h0);
    lit("unstall", 1'b1, 16'h0002, 24'h300789, 16'h0003);

    lat = 3;
    tick(0, 0, 0, 16'h0);
    tick(0, 0, 1, 16'h0040);
    tick(0, 0, 0, 16'h0);
    tick(0, 0, 0, 16'h0);
    chk("kill.req", 32'(imem_req), 32'h1);
    chk("kill.addr", 32'(imem_addr), 32'h0040);
    chk("kill.valid", 32'(ifid_valid), 32'h0);
    repeat (4) tick(0, 0, 0, 16'h0);
    lit("tgt", 1'b1, 16'h0040, 24'h5A0040, 16'h0041);

    lat = 1;
    tick(1, 0, 0, 16'h0);
    tick(1, 1, 1, 16'h0100);
    chk("flush.valid", 32'(ifid_valid), 32'h0);
    chk("flush.instr", 32'(ifid_instr), 32'h0);
    chk("flush.addr", 32'(imem_addr), 32'h0100);

    tick(0, 0, 1, 16'hFFFF);
    tick(0, 0, 0, 16'h0);
    chk("wrap.addr0", 32'(imem_addr), 32'hFFFF);
    tick(0, 0, 0, 16'h0);
    tick(0, 0, 0, 16'h0);
    lit("wrap", 1'b1, 16'hFFFF, 24'h5AFFFF, 16'h0000);
    chk("wrap.addr1", 32'(imem_addr), 32'h0000);

    tick(1, 0, 0, 16'h0);
    tick(1, 0, 0, 16'h0);
    tick(1, 0, 1, 16'h0200);
    chk("hold.addr", 32'(imem_addr), 32'h0200);
    tick(1, 0, 0, 16'h0);
    chk("pre_rst.valid", 32'(ifid_valid), 32'h1);

    #1;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst2.req", 32'(imem_req), 32'h0);
    lit("rst2", 1'b0, 16'h0, 24'h0, 16'h0);
    mq.delete();
    m_reset();
    stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.addr", 32'(imem_addr), 32'h0);
    chk_en = 1'b1;
    stray = 1'b1;
    tick(0, 0, 0, 16'h0);
    chk("stray.valid", 32'(ifid_valid), 32'h0);
    tick(0, 0, 0, 16'h0);
    lit("rel", 1'b1, 16'h0000, 24'h100123, 16'h0001);
    repeat (4) tick(0, 0, 0, 16'h0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
